// File: rtl/dma_page_addr_latch.sv
// DMA page/address latch for the 8237: latches the high address byte, adds a per-channel
// page from a CPU-writable register file, and forms the 20-bit system address.
module dma_page_addr_latch #(
  parameter int unsigned PAGE_BITS       = 4,
  parameter bit          DACK_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_cs_n,
  input  logic                    iow_n,
  input  logic                    ior_n,
  input  logic [1:0]              io_a,
  input  logic [7:0]              io_db_in,
  output logic [7:0]              io_db_out,
  output logic                    io_db_oe,
  input  logic [7:0]              dma_db,
  input  logic [7:0]              dma_a,
  input  logic                    adstb,
  input  logic                    aen,
  input  logic [3:0]              dack,
  output logic [16+PAGE_BITS-1:0] sys_addr,
  output logic                    sys_addr_oe,
  output logic                    dack_conflict
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned DB_W   = 8;

  logic [PAGE_BITS-1:0] page_q [NUM_CH];
  logic [DB_W-1:0]      hi_latch_q;
  logic [CH_W-1:0]      ch_hold_q;
  logic                 iow_prev_q;
  logic                 conflict_q;

  logic [CH_W-1:0]      io_ch;
  logic                 page_wr;
  logic [NUM_CH-1:0]    act;
  logic                 any_act;
  logic                 multi_act;
  logic [CH_W-1:0]      ch_sel;
  logic [DB_W-1:0]      hi;
  logic [PAGE_BITS-1:0] wr_page;

  // PC port order 0x80-0x83 maps to channels 0, 2, 3, 1
  always_comb begin
    io_ch = CH_W'(0);
    case (io_a)
      2'd0:    io_ch = CH_W'(0);
      2'd1:    io_ch = CH_W'(2);
      2'd2:    io_ch = CH_W'(3);
      default: io_ch = CH_W'(1);
    endcase
  end

  assign wr_page = io_db_in[PAGE_BITS-1:0];

  generate
    if (PAGE_BITS < DB_W) begin : g_unused_db
      logic unused_db_bits;
      assign unused_db_bits = ^io_db_in[DB_W-1:PAGE_BITS];
    end
  endgenerate

  // One write per falling edge of iow_n; the CPU cannot write while the DMA owns the bus
  assign page_wr = ~io_cs_n & ~iow_n & iow_prev_q & ~aen;

  // Readback path, forced to zero when not driving
  always_comb begin
    io_db_oe  = ~io_cs_n & ~ior_n & ~aen;
    io_db_out = '0;
    if (io_db_oe) begin
      io_db_out = DB_W'(page_q[io_ch]);
    end
  end

  // Acknowledge decode with lowest-index priority and multi-assert detection
  always_comb begin
    act       = DACK_ACTIVE_LOW ? ~dack : dack;
    any_act   = |act;
    multi_act = (act & (act - NUM_CH'(1))) != '0;
    ch_sel    = ch_hold_q;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (act[i]) begin
        ch_sel = CH_W'(i);
      end
    end
  end

  // Transparent high-byte latch: address is valid in the strobe cycle itself
  assign hi = adstb ? dma_db : hi_latch_q;

  assign sys_addr      = {page_q[ch_sel], hi, dma_a};
  assign sys_addr_oe   = aen;
  assign dack_conflict = conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        page_q[i] <= '0;
      end
      hi_latch_q <= '0;
      ch_hold_q  <= '0;
      iow_prev_q <= 1'b1;
      conflict_q <= 1'b0;
    end else begin
      iow_prev_q <= iow_n;
      if (page_wr) begin
        page_q[io_ch] <= wr_page;
      end
      if (adstb) begin
        hi_latch_q <= dma_db;
      end
      if (any_act) begin
        ch_hold_q <= ch_sel;
      end
      if (multi_act) begin
        conflict_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_page_addr_latch.sv
// Directed bench for dma_page_addr_latch: page register writes/reads, address assembly,
// channel priority and sticky conflict flag.
module tb_dma_page_addr_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_cs_n, iow_n, ior_n;
  logic [1:0]  io_a;
  logic [7:0]  io_db_in, io_db_out;
  logic        io_db_oe;
  logic [7:0]  dma_db, dma_a;
  logic        adstb, aen;
  logic [3:0]  dack;
  logic [19:0] sys_addr;
  logic        sys_addr_oe, dack_conflict;

  int checks = 0;
  int errors = 0;

  dma_page_addr_latch #(.PAGE_BITS(4), .DACK_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .io_cs_n(io_cs_n), .iow_n(iow_n), .ior_n(ior_n),
    .io_a(io_a), .io_db_in(io_db_in), .io_db_out(io_db_out), .io_db_oe(io_db_oe),
    .dma_db(dma_db), .dma_a(dma_a), .adstb(adstb), .aen(aen), .dack(dack),
    .sys_addr(sys_addr), .sys_addr_oe(sys_addr_oe), .dack_conflict(dack_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; io_cs_n = 1'b1; iow_n = 1'b1; ior_n = 1'b1; io_a = 2'd0;
    io_db_in = 8'h00; dma_db = 8'h00; dma_a = 8'h00; adstb = 1'b0; aen = 1'b0;
    dack = 4'hF;
    tick(); tick();
    check("rst_sys_addr", sys_addr, 20'h00000);
    check("rst_sys_addr_oe", 20'(sys_addr_oe), 20'h0);
    check("rst_io_db_oe", 20'(io_db_oe), 20'h0);
    check("rst_conflict", 20'(dack_conflict), 20'h0);
    reset = 1'b0;
    tick();

    // Write 0x0A to port 3 (ch1), read back
    io_cs_n = 1'b0; io_a = 2'd3; io_db_in = 8'h0A; iow_n = 1'b0;
    tick();
    iow_n = 1'b1; ior_n = 1'b0;
    #1;
    check("rd_ch1_data", 20'(io_db_out), 20'h0A);
    check("rd_ch1_oe", 20'(io_db_oe), 20'h1);
    io_a = 2'd0;
    #1;
    check("rd_ch0_zero", 20'(io_db_out), 20'h00);
    ior_n = 1'b1;
    #1;
    check("idle_oe", 20'(io_db_oe), 20'h0);
    check("idle_out", 20'(io_db_out), 20'h00);

    // Strobe without chip select is ignored
    io_cs_n = 1'b1; io_a = 2'd3; io_db_in = 8'h0C; iow_n = 1'b0;
    tick();
    iow_n = 1'b1;
    tick();
    io_cs_n = 1'b0; ior_n = 1'b0;
    #1;
    check("no_cs_write", 20'(io_db_out), 20'h0A);
    ior_n = 1'b1;

    // Upper data bits dropped: 0xF6 to ch0 stores 6
    io_a = 2'd0; io_db_in = 8'hF6; iow_n = 1'b0;
    tick();
    iow_n = 1'b1; ior_n = 1'b0;
    #1;
    check("rd_ch0_mask", 20'(io_db_out), 20'h06);
    ior_n = 1'b1;
    tick();

    // Held-low iow_n writes once (port 1 = ch2)
    io_a = 2'd1; io_db_in = 8'h05; iow_n = 1'b0;
    tick();
    io_db_in = 8'h07;
    tick(); tick(); tick();
    iow_n = 1'b1;
    tick();
    ior_n = 1'b0;
    #1;
    check("single_edge", 20'(io_db_out), 20'h05);
    ior_n = 1'b1;

    // Program ch2 = 3
    io_db_in = 8'h03; iow_n = 1'b0;
    tick();
    iow_n = 1'b1;
    tick();
    ior_n = 1'b0;
    #1;
    check("rd_ch2", 20'(io_db_out), 20'h03);
    ior_n = 1'b1; io_cs_n = 1'b1;

    // DMA on ch2 with strobe: address valid same cycle
    aen = 1'b1; adstb = 1'b1; dma_db = 8'h12; dma_a = 8'h34; dack = 4'b1011;
    #1;
    check("addr_adstb", sys_addr, 20'h31234);
    check("addr_oe", 20'(sys_addr_oe), 20'h1);
    tick();
    adstb = 1'b0; dma_db = 8'hFF; dma_a = 8'h35;
    #1;
    check("addr_hi_held", sys_addr, 20'h31235);
    tick();
    dack = 4'hF;
    #1;
    check("addr_ch_hold", sys_addr, 20'h31235);

    // CPU write/read during aen are blocked
    io_cs_n = 1'b0; io_a = 2'd1; io_db_in = 8'h09; iow_n = 1'b0;
    tick();
    iow_n = 1'b1; ior_n = 1'b0;
    #1;
    check("rd_blocked_aen", 20'(io_db_oe), 20'h0);
    check("rd_blocked_out", 20'(io_db_out), 20'h00);
    tick();
    aen = 1'b0;
    #1;
    check("wr_blocked_aen", 20'(io_db_out), 20'h03);
    check("addr_oe_off", 20'(sys_addr_oe), 20'h0);
    ior_n = 1'b1; io_cs_n = 1'b1;
    tick();

    // ch0 and ch1 both acknowledged: ch0 wins, conflict sticks
    aen = 1'b1; dack = 4'b1100; dma_a = 8'h00;
    #1;
    check("prio_ch0", sys_addr, 20'h61200);
    check("conflict_pre", 20'(dack_conflict), 20'h0);
    tick();
    check("conflict_set", 20'(dack_conflict), 20'h1);
    dack = 4'hF;
    tick();
    check("conflict_sticky", 20'(dack_conflict), 20'h1);
    check("prio_hold", sys_addr, 20'h61200);

    // Reset mid-DMA clears pages, latch and conflict
    dack = 4'b1110; dma_a = 8'h56; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_addr", sys_addr, 20'h00056);
    check("rst_mid_conflict", 20'(dack_conflict), 20'h0);
    dack = 4'hF; aen = 1'b0; io_cs_n = 1'b0; io_a = 2'd3; ior_n = 1'b0;
    #1;
    check("rst_mid_page", 20'(io_db_out), 20'h00);
    ior_n = 1'b1; io_cs_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
